// File: rtl/sdram_wr_pkg.sv
// Shared types and default geometry for the SDRAM write-burst controller.
package sdram_wr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      BURST = 2'd2
   } state_e;

   localparam int unsigned DEF_ADDR_W       = 24;
   localparam int unsigned DEF_BURST_LEN    = 16;
   localparam int unsigned DEF_BC_W         = 5;
   localparam int unsigned DEF_WINDOW_WORDS = 32'd1 << 20;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned USEDW_W    = 6;
   localparam int unsigned FIFO_DEPTH = 64;
   // FIFO level including the full case (0..64)
   localparam int unsigned LVL_W      = 7;

endpackage

// File: rtl/sdram_write_burst_ctrl.sv
// Drains a non-showahead write FIFO into an Avalon-MM SDRAM slave as bursts,
// walking a circular word-address window.
module sdram_write_burst_ctrl
   import sdram_wr_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
   parameter int unsigned BC_W         = DEF_BC_W,
   parameter int unsigned WINDOW_WORDS = DEF_WINDOW_WORDS
) (
   input  logic              clock,
   input  logic              aclr_n,
   input  logic              enable,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              flush,
   input  logic [DATA_W-1:0] fifo_q,
   input  logic [USEDW_W-1:0] fifo_usedw,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   output logic              fifo_rdreq,
   output logic [ADDR_W-1:0] avm_address,
   output logic [BC_W-1:0]   avm_burstcount,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic              flush_done,
   output logic [31:0]       words_written
);

   localparam int unsigned AW1 = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pointer_q, pointer_d, base_q, base_d;
   logic [ADDR_W-1:0] base_pend_q, base_pend_d, addr_q, addr_d;
   logic [BC_W-1:0]   bc_q, bc_d, len_q, len_d, remaining_q, remaining_d;
   logic              start_pend_q, start_pend_d, flush_pend_q, flush_pend_d;
   logic              write_q, write_d, flush_done_q, flush_done_d, busy_q, busy_d;
   logic [31:0]       ww_q, ww_d;
   logic [LVL_W-1:0]  level, cand;
   logic [AW1-1:0]    win_end, room, ptr_next;
   logic              accept, pend_eff, rdreq;

   assign level    = fifo_full ? LVL_W'(FIFO_DEPTH) : LVL_W'(fifo_usedw);
   assign win_end  = AW1'(base_q) + AW1'(WINDOW_WORDS);
   assign room     = win_end - AW1'(pointer_q);
   assign ptr_next = AW1'(pointer_q) + AW1'(bc_q);
   assign accept   = write_q & ~avm_waitrequest;
   assign pend_eff = flush_pend_q | flush;

   // Burst length: buffered words capped at BURST_LEN, then at room left before the window end
   always_comb begin
      cand = (level < LVL_W'(BURST_LEN)) ? level : LVL_W'(BURST_LEN);
      if (AW1'(cand) > room) cand = LVL_W'(room);
   end

   always_comb begin
      state_d      = state_q;
      pointer_d    = pointer_q;
      base_d       = base_q;
      base_pend_d  = base_pend_q;
      start_pend_d = start_pend_q;
      flush_pend_d = flush_pend_q | flush;
      len_d        = len_q;
      addr_d       = addr_q;
      bc_d         = bc_q;
      remaining_d  = remaining_q;
      write_d      = write_q;
      ww_d         = ww_q;
      flush_done_d = 1'b0;
      rdreq        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start || start_pend_q) begin
               base_d       = start ? base_addr : base_pend_q;
               pointer_d    = start ? base_addr : base_pend_q;
               ww_d         = '0;
               start_pend_d = 1'b0;
            end else if (pend_eff && fifo_empty) begin
               flush_done_d = 1'b1;
               flush_pend_d = 1'b0;
            end else if (enable && ((level >= LVL_W'(BURST_LEN)) || (pend_eff && !fifo_empty))) begin
               len_d   = BC_W'(cand);
               state_d = FETCH;
            end
         end
         FETCH: begin
            rdreq       = 1'b1;
            addr_d      = pointer_q;
            bc_d        = len_q;
            remaining_d = len_q;
            write_d     = 1'b1;
            state_d     = BURST;
         end
         BURST: begin
            if (accept) begin
               remaining_d = remaining_q - BC_W'(1);
               ww_d        = ww_q + 32'd1;
               rdreq       = (remaining_q > BC_W'(1));
               if (remaining_q == BC_W'(1)) begin
                  write_d   = 1'b0;
                  pointer_d = (ptr_next >= win_end) ? base_q : ADDR_W'(ptr_next);
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A start seen mid-burst is replayed in the next IDLE cycle
      if (start && (state_q != IDLE)) begin
         start_pend_d = 1'b1;
         base_pend_d  = base_addr;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q      <= IDLE;
         pointer_q    <= '0;
         base_q       <= '0;
         base_pend_q  <= '0;
         start_pend_q <= 1'b0;
         flush_pend_q <= 1'b0;
         len_q        <= '0;
         addr_q       <= '0;
         bc_q         <= '0;
         remaining_q  <= '0;
         write_q      <= 1'b0;
         ww_q         <= '0;
         flush_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pointer_q    <= pointer_d;
         base_q       <= base_d;
         base_pend_q  <= base_pend_d;
         start_pend_q <= start_pend_d;
         flush_pend_q <= flush_pend_d;
         len_q        <= len_d;
         addr_q       <= addr_d;
         bc_q         <= bc_d;
         remaining_q  <= remaining_d;
         write_q      <= write_d;
         ww_q         <= ww_d;
         flush_done_q <= flush_done_d;
         busy_q       <= busy_d;
      end
   end

   assign fifo_rdreq     = rdreq;
   assign avm_address    = addr_q;
   assign avm_burstcount = bc_q;
   assign avm_write      = write_q;
   assign avm_writedata  = fifo_q;
   assign busy           = busy_q;
   assign flush_done     = flush_done_q;
   assign words_written  = ww_q;

endmodule

// File: tb/tb_sdram_write_burst_ctrl.sv
// Directed bench: FIFO model feeds the controller, scoreboard checks every Avalon write.
module tb_sdram_write_burst_ctrl;

   localparam int unsigned ADDR_W = 24;
   localparam int unsigned BL     = 16;
   localparam int unsigned BC_W   = 5;
   localparam int unsigned WIN    = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BC_W-1:0]   bc;
      logic [15:0]       data;
   } exp_t;

   logic              clock, aclr_n, enable, start, flush;
   logic [ADDR_W-1:0] base_addr;
   logic [15:0]       fifo_q;
   logic [5:0]        fifo_usedw;
   logic              fifo_empty, fifo_full, fifo_rdreq;
   logic [ADDR_W-1:0] avm_address;
   logic [BC_W-1:0]   avm_burstcount;
   logic              avm_write, avm_waitrequest, busy, flush_done;
   logic [15:0]       avm_writedata;
   logic [31:0]       words_written;

   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  stall_en = 1'b0;
   logic [15:0] next_data = 16'd0;
   logic [15:0] exp_data  = 16'd0;

   // Non-showahead FIFO model (64 deep, usedw wraps to 0 when full)
   logic [15:0] fmem [64];
   int          fcount = 0, frd = 0, fwr = 0;
   logic        wr_en = 1'b0, fifo_clr = 1'b0;
   logic [15:0] wr_data = 16'd0;

   sdram_write_burst_ctrl #(
      .ADDR_W(ADDR_W), .BURST_LEN(BL), .BC_W(BC_W), .WINDOW_WORDS(WIN)
   ) dut (
      .clock(clock), .aclr_n(aclr_n), .enable(enable), .start(start),
      .base_addr(base_addr), .flush(flush), .fifo_q(fifo_q),
      .fifo_usedw(fifo_usedw), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_rdreq(fifo_rdreq), .avm_address(avm_address),
      .avm_burstcount(avm_burstcount), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .flush_done(flush_done), .words_written(words_written)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial fifo_q = 16'd0;
   always @(posedge clock) begin
      if (fifo_clr) begin
         fcount <= 0; frd <= 0; fwr <= 0;
      end else begin
         if (wr_en) begin
            fmem[fwr] <= wr_data;
            fwr <= (fwr + 1) % 64;
         end
         if (fifo_rdreq && fcount > 0) begin
            fifo_q <= fmem[frd];
            frd <= (frd + 1) % 64;
         end
         fcount <= fcount + (wr_en ? 1 : 0) - ((fifo_rdreq && fcount > 0) ? 1 : 0);
      end
   end
   assign fifo_usedw = 6'(fcount);
   assign fifo_full  = (fcount == 64);
   assign fifo_empty = (fcount == 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every write cycle is compared with the head entry, popped on accept
   always @(negedge clock) begin
      if (fifo_rdreq) check("rdreq_nonempty", 32'(fcount != 0), 32'd1);
      if (avm_write) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(exp_q.size()), 32'd1);
         end else begin
            check("addr", 32'(avm_address), 32'(exp_q[0].addr));
            check("bc", 32'(avm_burstcount), 32'(exp_q[0].bc));
            check("data", 32'(avm_writedata), 32'(exp_q[0].data));
            if (avm_waitrequest) check("rdreq_stall", 32'(fifo_rdreq), 32'd0);
            else void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   task automatic push_n(input int n);
      for (int i = 0; i < n; i++) begin
         wr_en = 1'b1;
         wr_data = next_data;
         next_data++;
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic expect_burst(input logic [ADDR_W-1:0] addr, input int bc);
      for (int i = 0; i < bc; i++) begin
         exp_q.push_back('{addr: addr, bc: BC_W'(bc), data: exp_data});
         exp_data++;
      end
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] a);
      base_addr = a;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         tick();
      end
      check(tag, 32'(exp_q.size()), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_flush(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (flush_done) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      aclr_n = 1'b0; enable = 1'b0; start = 1'b0; flush = 1'b0;
      base_addr = '0; avm_waitrequest = 1'b0;
      repeat (3) tick();
      check("rst_write", 32'(avm_write), 32'd0);
      check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", 32'(avm_address), 32'd0);
      check("rst_bc", 32'(avm_burstcount), 32'd0);
      check("rst_ww", words_written, 32'd0);
      check("rst_fdone", 32'(flush_done), 32'd0);
      aclr_n = 1'b1;
      tick();

      // 1: single full burst, plus trigger-to-write latency
      enable = 1'b1;
      pulse_start(24'h100);
      expect_burst(24'h100, 16);
      push_n(16);
      tick();
      check("t1_fetch_rdreq", 32'(fifo_rdreq), 32'd1);
      check("t1_fetch_write", 32'(avm_write), 32'd0);
      check("t1_fetch_busy", 32'(busy), 32'd1);
      tick();
      check("t1_first_write", 32'(avm_write), 32'd1);
      wait_idle("t1_drain");
      check("t1_ww", words_written, 32'd16);

      // 2: 40 words -> two full bursts, remainder of 8 held until flush
      pulse_start(24'h400);
      expect_burst(24'h400, 16);
      expect_burst(24'h410, 16);
      push_n(40);
      wait_idle("t2_drain");
      repeat (4) tick();
      check("t2_left", 32'(fcount), 32'd8);
      check("t2_idle_write", 32'(avm_write), 32'd0);
      expect_burst(24'h400, 8);
      pulse_flush();
      wait_flush("t2_fdone");
      wait_idle("t2_flush_drain");
      check("t2_ww", words_written, 32'd40);

      // 3: random waitrequest during a full burst
      pulse_start(24'h800);
      stall_en = 1'b1;
      expect_burst(24'h800, 16);
      push_n(16);
      wait_idle("t3_drain");
      stall_en = 1'b0;
      tick();
      check("t3_ww", words_written, 32'd16);

      // 4: window wrap, then a flush split across the window end
      pulse_start(24'h0);
      expect_burst(24'h0, 16);
      expect_burst(24'h10, 16);
      expect_burst(24'h0, 16);
      push_n(48);
      wait_idle("t4_drain");
      expect_burst(24'h10, 8);
      push_n(8);
      pulse_flush();
      wait_flush("t4_fdone1");
      wait_idle("t4_drain2");
      enable = 1'b0;
      push_n(16);
      pulse_flush();
      repeat (3) tick();
      check("t4_hold_busy", 32'(busy), 32'd0);
      expect_burst(24'h18, 8);
      expect_burst(24'h0, 8);
      enable = 1'b1;
      wait_flush("t4_fdone2");
      wait_idle("t4_drain3");
      check("t4_ww", words_written, 32'd72);

      // 5: full FIFO (usedw reads 0) counts as 64 words
      enable = 1'b0;
      pulse_start(24'h200);
      push_n(64);
      tick();
      check("t5_full", 32'(fifo_full), 32'd1);
      check("t5_wait_busy", 32'(busy), 32'd0);
      expect_burst(24'h200, 16);
      expect_burst(24'h210, 16);
      expect_burst(24'h200, 16);
      expect_burst(24'h210, 16);
      enable = 1'b1;
      wait_idle("t5_drain");
      check("t5_ww", words_written, 32'd64);

      // 6: async reset mid-burst, then flush on an empty FIFO
      pulse_start(24'h300);
      expect_burst(24'h300, 16);
      push_n(16);
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() <= 11) break;
         tick();
      end
      check("t6_reached_word5", 32'(exp_q.size() <= 11), 32'd1);
      aclr_n = 1'b0;
      #1;
      check("t6_rst_write", 32'(avm_write), 32'd0);
      check("t6_rst_rdreq", 32'(fifo_rdreq), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_addr", 32'(avm_address), 32'd0);
      check("t6_rst_bc", 32'(avm_burstcount), 32'd0);
      check("t6_rst_ww", words_written, 32'd0);
      exp_q.delete();
      fifo_clr = 1'b1;
      tick();
      fifo_clr = 1'b0;
      exp_data = next_data;
      aclr_n = 1'b1;
      tick();
      check("t6_post_busy", 32'(busy), 32'd0);
      expect_burst(24'h0, 16);
      push_n(16);
      wait_idle("t6_ptr_zero");
      check("t6_ww", words_written, 32'd16);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t6_fdone_pulse", 32'(flush_done), 32'd1);
      check("t6_fdone_nowrite", 32'(avm_write), 32'd0);
      tick();
      check("t6_fdone_clear", 32'(flush_done), 32'd0);
      check("t6_fdone_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
